uart_fifo_ctrl: RTL and testbench

UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

---
 rtl/uart_fifo_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: byte FIFOs between a CPU-style bus and a UART core.
//   TX path: bus pushes (wr_i/wdata_i) into a DEPTH-byte FIFO; the TX FSM pops
//            one byte at a time and hands it to the UART with a one-cycle
//            uart_wr_o strobe, then waits for uart_busy_i to rise and fall.
//   RX path: the RX FSM pushes uart_rx_data_i when uart_valid_i is high and
//            acknowledges with a one-cycle uart_rd_o; the bus pops with rd_i
//            and sees the head on rdata_o (show-ahead, 8'h00 when empty).
// Ports: clk, reset_i (async, active-high), wr_i, wdata_i, rd_i, rdata_o,
//        tx_full_o, tx_empty_o, rx_full_o, rx_empty_o, rx_overrun_o,
//        clr_overrun_i, uart_wr_o, uart_tx_data_o, uart_busy_i, uart_rd_o,
//        uart_rx_data_i, uart_valid_i.
// Build option: define UART_FIFO_OVERRUN_EN to drop-and-flag bytes arriving
//        while the RX FIFO is full; otherwise the RX side back-pressures the
//        UART by withholding the acknowledge.
module uart_fifo_ctrl #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       wr_i,
  input  logic [7:0] wdata_i,
  input  logic       rd_i,
  output logic [7:0] rdata_o,
  output logic       tx_full_o,
  output logic       tx_empty_o,
  output logic       rx_full_o,
  output logic       rx_empty_o,
  output logic       rx_overrun_o,
  input  logic       clr_overrun_i,
  output logic       uart_wr_o,
  output logic [7:0] uart_tx_data_o,
  input  logic       uart_busy_i,
  output logic       uart_rd_o,
  input  logic [7:0] uart_rx_data_i,
  input  logic       uart_valid_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_STROBE, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT_CLR} rx_state_t;

  tx_state_t     r_tx_state;
  rx_state_t     r_rx_state;

  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wptr, r_tx_rptr;
  logic [CW-1:0] r_tx_cnt;
  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wptr, r_rx_rptr;
  logic [CW-1:0] r_rx_cnt;

  logic          r_uart_wr, r_uart_rd;
  logic [7:0]    r_uart_tx_data;

  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;

  assign w_tx_full  = (r_tx_cnt == CW'(DEPTH));
  assign w_tx_empty = (r_tx_cnt == CW'(0));
  assign w_rx_full  = (r_rx_cnt == CW'(DEPTH));
  assign w_rx_empty = (r_rx_cnt == CW'(0));

  // A push while full is dropped even if the TX FSM pops on the same edge.
  assign w_tx_push = wr_i && !w_tx_full;
  assign w_tx_pop  = (r_tx_state == TX_IDLE) && !w_tx_empty;
  assign w_rx_push = (r_rx_state == RX_IDLE) && uart_valid_i && !w_rx_full;
  assign w_rx_pop  = rd_i && !w_rx_empty;

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + AW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // FIFO storage is not reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= wdata_i;
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= uart_rx_data_i;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + AW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + AW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // TX FSM: pop in IDLE, strobe once, then follow the UART busy handshake
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_tx_state     <= TX_IDLE;
      r_uart_wr      <= 1'b0;
      r_uart_tx_data <= 8'h00;
    end else begin
      r_uart_wr <= 1'b0;
      case (r_tx_state)
        TX_IDLE: begin
          if (!w_tx_empty) begin
            r_uart_tx_data <= r_tx_mem[r_tx_rptr];
            r_uart_wr      <= 1'b1;
            r_tx_state     <= TX_STROBE;
          end
        end
        TX_STROBE:    r_tx_state <= TX_WAIT_BUSY;
        TX_WAIT_BUSY: if (uart_busy_i)  r_tx_state <= TX_WAIT_DONE;
        TX_WAIT_DONE: if (!uart_busy_i) r_tx_state <= TX_IDLE;
        default:      r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX FSM: accept a byte, acknowledge once, wait for valid to drop
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_rx_state <= RX_IDLE;
      r_uart_rd  <= 1'b0;
    end else begin
      r_uart_rd <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_push) begin
            r_uart_rd  <= 1'b1;
            r_rx_state <= RX_ACK;
          end
`ifdef UART_FIFO_OVERRUN_EN
          else if (uart_valid_i) begin
            // FIFO full: byte is dropped but still acknowledged
            r_uart_rd  <= 1'b1;
            r_rx_state <= RX_ACK;
          end
`endif
        end
        RX_ACK:      r_rx_state <= RX_WAIT_CLR;
        RX_WAIT_CLR: if (!uart_valid_i) r_rx_state <= RX_IDLE;
        default:     r_rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_FIFO_OVERRUN_EN
  logic r_rx_overrun;
  logic w_ovr_set;
  assign w_ovr_set = (r_rx_state == RX_IDLE) && uart_valid_i && w_rx_full;

  // Sticky overrun; a set wins over a simultaneous clear
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i)            r_rx_overrun <= 1'b0;
    else if (w_ovr_set)     r_rx_overrun <= 1'b1;
    else if (clr_overrun_i) r_rx_overrun <= 1'b0;
  end
  assign rx_overrun_o = r_rx_overrun;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_overrun_i;
  assign rx_overrun_o = 1'b0;
`endif

  assign rdata_o        = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];
  assign tx_full_o      = w_tx_full;
  assign tx_empty_o     = w_tx_empty;
  assign rx_full_o      = w_rx_full;
  assign rx_empty_o     = w_rx_empty;
  assign uart_wr_o      = r_uart_wr;
  assign uart_rd_o      = r_uart_rd;
  assign uart_tx_data_o = r_uart_tx_data;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Randomized bench for uart_fifo_ctrl against a queue-based reference model.
// The bench also plays both UART roles: a transmitter that raises busy for a
// random number of cycles after each strobe, and a receiver source that holds
// a byte valid until acknowledged, then idles for a random gap.
module tb_uart_fifo_ctrl;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       wr_i, rd_i, clr_overrun_i, uart_busy_i, uart_valid_i;
  logic [7:0] wdata_i, uart_rx_data_i;
  logic [7:0] rdata_o, uart_tx_data_o;
  logic       tx_full_o, tx_empty_o, rx_full_o, rx_empty_o;
  logic       rx_overrun_o, uart_wr_o, uart_rd_o;

  uart_fifo_ctrl #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .wr_i           (wr_i),
    .wdata_i        (wdata_i),
    .rd_i           (rd_i),
    .rdata_o        (rdata_o),
    .tx_full_o      (tx_full_o),
    .tx_empty_o     (tx_empty_o),
    .rx_full_o      (rx_full_o),
    .rx_empty_o     (rx_empty_o),
    .rx_overrun_o   (rx_overrun_o),
    .clr_overrun_i  (clr_overrun_i),
    .uart_wr_o      (uart_wr_o),
    .uart_tx_data_o (uart_tx_data_o),
    .uart_busy_i    (uart_busy_i),
    .uart_rd_o      (uart_rd_o),
    .uart_rx_data_i (uart_rx_data_i),
    .uart_valid_i   (uart_valid_i)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  // Reference model state
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int         tx_timer;   // edges until the transmit engine may take another byte
  int         pend_n;     // busy length chosen for the byte just handed over
  int         busy_left;  // remaining busy cycles of the UART transmitter
  bit         exp_wr, exp_rd, exp_ovr;
  logic [7:0] exp_txd;
  bit         src_valid, src_pending;
  int         src_gap;
  logic [7:0] src_data;
  bit         first_wr;

  // Stimulus knobs (percentages / busy range)
  int p_wr, p_rd, p_clr, busy_lo, busy_hi;

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_rdata;
    exp_rdata = (rxq.size() != 0) ? rxq[0] : 8'h00;
    check_val("tx_empty",  8'(tx_empty_o),   8'(txq.size() == 0));
    check_val("tx_full",   8'(tx_full_o),    8'(txq.size() == DEPTH));
    check_val("rx_empty",  8'(rx_empty_o),   8'(rxq.size() == 0));
    check_val("rx_full",   8'(rx_full_o),    8'(rxq.size() == DEPTH));
    check_val("rdata",     rdata_o,          exp_rdata);
    check_val("uart_wr",   8'(uart_wr_o),    8'(exp_wr));
    check_val("tx_data",   uart_tx_data_o,   exp_txd);
    check_val("uart_rd",   8'(uart_rd_o),    8'(exp_rd));
    check_val("overrun",   8'(rx_overrun_o), 8'(exp_ovr));
    check_val("wr_busy",   8'(uart_wr_o & uart_busy_i), 8'h00);
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    tx_timer    = 0;
    pend_n      = 0;
    busy_left   = 0;
    exp_wr      = 1'b0;
    exp_rd      = 1'b0;
    exp_ovr     = 1'b0;
    exp_txd     = 8'h00;
    src_valid   = 1'b0;
    src_pending = 1'b0;
    src_gap     = 2;
    src_data    = 8'h5A;
  endtask

  // One rising edge of the reference: uses the inputs held during the cycle
  task automatic model_step();
    bit prev_wr, prev_rd, tx_full_pre, rx_full_pre, pop, ovr_set;
    prev_wr = exp_wr;
    prev_rd = exp_rd;

    // UART transmitter model: busy begins the cycle after the strobe
    if (prev_wr) busy_left = pend_n;
    else if (busy_left > 0) busy_left--;

    // TX: engine takes a byte whenever it is free; a handshake of busy length
    // N keeps it occupied for N+3 edges in total
    tx_full_pre = (txq.size() == DEPTH);
    pop = (tx_timer == 0) && (txq.size() != 0);
    exp_wr = pop;
    if (pop) begin
      exp_txd  = txq.pop_front();
      pend_n   = $urandom_range(busy_hi, busy_lo);
      tx_timer = pend_n + 2;
    end else if (tx_timer > 0) begin
      tx_timer--;
    end
    if (wr_i && !tx_full_pre) txq.push_back(wdata_i);

    // RX: bus pop and UART push both act on the pre-edge occupancy
    rx_full_pre = (rxq.size() == DEPTH);
    exp_rd  = 1'b0;
    ovr_set = 1'b0;
    if (rd_i && rxq.size() != 0) rxq.delete(0);
    if (src_pending && src_valid) begin
      if (!rx_full_pre) begin
        rxq.push_back(src_data);
        exp_rd      = 1'b1;
        src_pending = 1'b0;
      end
`ifdef UART_FIFO_OVERRUN_EN
      else begin
        ovr_set     = 1'b1;
        exp_rd      = 1'b1;
        src_pending = 1'b0;
      end
`endif
    end
    if (ovr_set) exp_ovr = 1'b1;
    else if (clr_overrun_i) exp_ovr = 1'b0;

    // UART receiver source: drop valid after the acknowledge, then a gap
    if (prev_rd) begin
      src_valid = 1'b0;
      src_gap   = $urandom_range(6, 1);
    end else if (!src_valid) begin
      if (src_gap > 1) src_gap--;
      else begin
        src_valid   = 1'b1;
        src_pending = 1'b1;
        src_data    = 8'($urandom);
      end
    end
  endtask

  task automatic drive_inputs();
    wr_i          = ($urandom_range(99, 0) < p_wr);
    wdata_i       = 8'($urandom);
    if (first_wr) begin
      wr_i     = 1'b1;
      wdata_i  = 8'h41;
      first_wr = 1'b0;
    end
    rd_i           = ($urandom_range(99, 0) < p_rd);
    clr_overrun_i  = ($urandom_range(99, 0) < p_clr);
    uart_busy_i    = (busy_left > 0);
    uart_valid_i   = src_valid;
    uart_rx_data_i = src_data;
  endtask

  // Entered and left at a falling edge
  task automatic run_cycle();
    check_outputs();
    drive_inputs();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    model_reset();
    wr_i = 1'b0; wdata_i = 8'h00; rd_i = 1'b0; clr_overrun_i = 1'b0;
    uart_busy_i = 1'b0; uart_valid_i = 1'b0; uart_rx_data_i = 8'h00;
    #1;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset_i = 1'b0;
  endtask

  task automatic set_knobs(input int wr_p, input int rd_p, input int clr_p,
                           input int blo, input int bhi);
    p_wr = wr_p; p_rd = rd_p; p_clr = clr_p; busy_lo = blo; busy_hi = bhi;
  endtask

  initial begin
    reset_i = 1'b1;
    wr_i = 1'b0; wdata_i = 8'h00; rd_i = 1'b0; clr_overrun_i = 1'b0;
    uart_busy_i = 1'b0; uart_valid_i = 1'b0; uart_rx_data_i = 8'h00;
    first_wr = 1'b1;
    set_knobs(40, 50, 5, 1, 3);
    @(negedge clk);
    do_reset();

    // Light traffic, short UART busy
    for (int i = 0; i < 600; i++) run_cycle();

    // Slow UART and a lazy bus reader: both FIFOs fill up
    set_knobs(70, 4, 3, 20, 40);
    for (int i = 0; i < 500; i++) run_cycle();

    // Drain with frequent overrun clears
    set_knobs(10, 70, 25, 2, 6);
    for (int i = 0; i < 200; i++) run_cycle();

    // Reset in the middle of a handshake with bytes still queued
    set_knobs(100, 0, 0, 8, 12);
    for (int i = 0; i < 200; i++) begin
      if (busy_left > 1 && txq.size() >= 3) break;
      run_cycle();
    end
    do_reset();
    set_knobs(0, 0, 0, 2, 4);
    for (int i = 0; i < 20; i++) run_cycle();

    // Mixed traffic after reset
    set_knobs(50, 50, 10, 1, 10);
    for (int i = 0; i < 600; i++) run_cycle();

    check_outputs();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
